reg_bank_reader: RTL and testbench
==================================

# reg_bank_reader

Read-side companion to the team's N-bit storage registers. It accepts a burst read request (start address, word count) against a bank of DEPTH registers whose parallel outputs are presented flattened on one bus. It then streams the selected words out one per handshake over a valid/ready interface. It sits between the register bank and any consumer (bus bridge, debug port, display driver) that needs ordered, flow-controlled readback.

## Interface
Parameters:
- N, 4, data width of one register word
- DEPTH, 8, number of registers in the bank (power of two)
- ADDR_W, 3, address width, equal to log2(DEPTH)

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- BankData  input  DEPTH*N  flattened register outputs; word i occupies bits [i*N +: N]
- ReqValid  input  1  request strobe
- ReqReady  output  1  block can accept a request
- ReqAddr  input  ADDR_W  first word address
- ReqCount  input  ADDR_W+1  number of words, 0..DEPTH
- OutValid  output  1  OutData/OutAddr/OutLast valid
- OutReady  input  1  consumer accepts the current word
- OutData  output  N  word data
- OutAddr  output  ADDR_W  address of the word on OutData
- OutLast  output  1  current word is the final word of the burst
- Busy  output  1  burst in progress

The design uses one clock. Reset is synchronous and active-high; the polarity and synchronicity are fixed.

## Operation
- FSM states:
  - IDLE: ReqReady=1, OutValid=0.
  - SEND: ReqReady=0, OutValid=1.
- Request accept: ReqValid && ReqReady.
  - If ReqCount==0, the request is accepted and dropped. The FSM stays in IDLE and produces no output.
  - Otherwise the FSM latches addr=ReqAddr and remaining=ReqCount, loads the output register with word ReqAddr, and goes to SEND.
- In SEND, OutValid stays high. OutData, OutAddr and OutLast (remaining==1) hold stable while OutReady=0.
- Output handshake (OutValid && OutReady):
  - If remaining==1, go to IDLE.
  - Else addr advances to (addr+1) mod DEPTH (wraps DEPTH-1 to 0), remaining decrements, and the output register loads the next word.
- ReqValid is ignored in SEND. A new request cannot be accepted in the same cycle as the last handshake.
- Busy = (state==SEND).
- Reset, including mid-burst: state=IDLE, OutValid=0, OutData=0, OutAddr=0, OutLast=0, Busy=0, ReqReady=1 from the next cycle. The burst in progress is discarded.
- Arithmetic: the address increment is modulo DEPTH by truncation to ADDR_W bits. remaining is ADDR_W+1 bits and never underflows.

## Timing
- Request accepted in cycle T → first word valid in cycle T+1.
- With OutReady held high, one word transfers per cycle. The last word of count C is valid in cycle T+C, and ReqReady is high again in cycle T+C+1.
- OutReady low for k cycles stretches the burst by k cycles and leaves the outputs unchanged.
- ReqReady is a combinational decode of the state only. OutData is registered.

## Configuration
- REG_READER_SNAPSHOT_EN defined:
  - At request accept, the entire BankData is captured into an internal DEPTH*N snapshot.
  - All words of the burst come from that snapshot, so the burst is coherent even if the bank changes mid-burst.
- Not defined:
  - No snapshot storage.
  - Each word is sampled from live BankData on the clock edge that loads the output register (request accept, or the preceding handshake).
  - Later bank changes affect only words not yet loaded.

## Structure
- Shared package/header reg_reader_pkg holds:
  - FSM state encoding (IDLE, SEND)
  - default N/DEPTH/ADDR_W constants
- Sub-module reg_word_mux: a combinational DEPTH:1 selector of an N-bit word from the flattened bus (live or snapshot) by address.
- The top level contains the FSM, the address and remaining counters, the output register, and the optional snapshot.

## Test plan
Defaults N=4, DEPTH=8, and word i = i+1 unless noted.
- Reset sanity: Reset high 2 cycles → all outputs 0, ReqReady=1 after release.
- Basic burst: ReqAddr=2, ReqCount=3, OutReady=1 → OutData 3,4,5 in cycles T+1..T+3 with OutAddr 2,3,4; OutLast only on 5; ReqReady=1 at T+4.
- Wrap plus backpressure:
  - Stimulus: ReqAddr=6, ReqCount=4, OutReady low 2 cycles on the second word.
  - Response: words 7,8,1,2 at addresses 6,7,0,1; the second word is held stable for 3 cycles.
- Zero count and busy-ignore:
  - ReqCount=0 → no OutValid, stays IDLE.
  - ReqValid pulsed during SEND → ignored, burst unaffected.
- Reset mid-burst: Reset during the 2nd of 4 words → next cycle OutValid=0, Busy=0; a new request for addr 0, count 1 returns 1.
- Bank change mid-burst: ReqAddr=0, ReqCount=2, and word1 is changed to 0xF in cycle T+1.
  - With REG_READER_SNAPSHOT_EN: second word = 2.
  - Without it: second word = 0xF.

Source files
------------

// File: rtl/reg_reader_pkg.sv
// Shared constants for reg_bank_reader: FSM encoding and default geometry.
// Optional macro REG_READER_SNAPSHOT_EN enables burst-coherent bank capture.
package reg_reader_pkg;

    localparam int DEF_N      = 4;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ADDR_W = 3;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

endpackage

// File: rtl/reg_word_mux.sv
// Combinational DEPTH:1 word selector over a flattened register bus.
module reg_word_mux
    import reg_reader_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [DEPTH*N-1:0] bank,
    input  logic [ADDR_W-1:0]  sel,
    output logic [N-1:0]       word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == ADDR_W'(i))
                word = bank[i*N +: N];
        end
    end

endmodule

// File: rtl/reg_bank_reader.sv
// Burst reader streaming words from a flattened register bank over valid/ready.
// Define REG_READER_SNAPSHOT_EN to serve each burst from a capture taken at accept.
module reg_bank_reader
    import reg_reader_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [DEPTH*N-1:0]  BankData,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic [ADDR_W-1:0]   ReqAddr,
    input  logic [ADDR_W:0]     ReqCount,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [N-1:0]        OutData,
    output logic [ADDR_W-1:0]   OutAddr,
    output logic                OutLast,
    output logic                Busy
);

    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [N-1:0]      data_q;
    logic [ADDR_W-1:0] nxt_addr;
    logic [ADDR_W-1:0] sel;
    logic [DEPTH*N-1:0] src;
    logic [N-1:0]      word;
    logic              last;

    assign ReqReady = (state == S_IDLE);
    assign OutValid = (state == S_SEND);
    assign Busy     = OutValid;
    assign OutData  = data_q;
    assign OutAddr  = addr;
    assign last     = (remaining == ONE);
    assign OutLast  = last;

    // Wraps DEPTH-1 to 0 by truncation.
    assign nxt_addr = addr + 1'b1;
    assign sel      = (state == S_IDLE) ? ReqAddr : nxt_addr;

`ifdef REG_READER_SNAPSHOT_EN
    logic [DEPTH*N-1:0] snap;

    // At accept the snapshot is being written, so read live data then.
    assign src = (state == S_IDLE) ? BankData : snap;

    always_ff @(posedge Clock) begin
        if (Reset)
            snap <= '0;
        else if (ReqValid && ReqReady)
            snap <= BankData;
    end
`else
    assign src = BankData;
`endif

    reg_word_mux #(
        .N      (N),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mux (
        .bank (src),
        .sel  (sel),
        .word (word)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            data_q    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (ReqValid && ReqCount != '0) begin
                        state     <= S_SEND;
                        addr      <= ReqAddr;
                        remaining <= ReqCount;
                        data_q    <= word;
                    end
                end
                S_SEND: begin
                    if (OutReady) begin
                        remaining <= remaining - ONE;
                        if (last) begin
                            state <= S_IDLE;
                        end else begin
                            addr   <= nxt_addr;
                            data_q <= word;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Scoreboard bench for reg_bank_reader: directed bursts, wrap, backpressure,
// zero count, busy-ignore, mid-burst reset and mid-burst bank change.
module tb_reg_bank_reader;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] BankData;
    logic        ReqValid;
    logic        ReqReady;
    logic [2:0]  ReqAddr;
    logic [3:0]  ReqCount;
    logic        OutValid;
    logic        OutReady;
    logic [3:0]  OutData;
    logic [2:0]  OutAddr;
    logic        OutLast;
    logic        Busy;

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] a;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 Clock = ~Clock;

    reg_bank_reader dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .BankData (BankData),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqAddr  (ReqAddr),
        .ReqCount (ReqCount),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .OutAddr  (OutAddr),
        .OutLast  (OutLast),
        .Busy     (Busy)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input int d, input int a, input int l);
        exp_t e;
        e.d = 4'(d);
        e.a = 3'(a);
        e.l = 1'(l);
        sb.push_back(e);
    endtask

    task automatic request(input int a, input int c);
        ReqValid = 1'b1;
        ReqAddr  = 3'(a);
        ReqCount = 4'(c);
        tick();
        ReqValid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!ReqReady && n < 40) begin
            tick();
            n++;
        end
        check({name, "_idle_timeout"}, int'(ReqReady), 1);
    endtask

    function automatic logic [31:0] default_bank();
        logic [31:0] b;
        for (int i = 0; i < 8; i++)
            b[i*4 +: 4] = 4'(i + 1);
        return b;
    endfunction

    // Monitor: every valid cycle is compared to the queue head; stalled
    // cycles therefore also check that the held word stays unchanged.
    always @(negedge Clock) begin
        if (!Reset && OutValid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got d=%0d a=%0d, expected none",
                         OutData, OutAddr);
            end else begin
                check("out_data", int'(OutData), int'(sb[0].d));
                check("out_addr", int'(OutAddr), int'(sb[0].a));
                check("out_last", int'(OutLast), int'(sb[0].l));
                if (OutReady)
                    void'(sb.pop_front());
            end
        end
    end

    initial begin
        Reset    = 1'b1;
        BankData = default_bank();
        ReqValid = 1'b0;
        ReqAddr  = '0;
        ReqCount = '0;
        OutReady = 1'b1;

        // Reset sanity
        tick();
        tick();
        check("rst_outvalid", int'(OutValid), 0);
        check("rst_outdata", int'(OutData), 0);
        check("rst_outaddr", int'(OutAddr), 0);
        check("rst_outlast", int'(OutLast), 0);
        check("rst_busy", int'(Busy), 0);
        Reset = 1'b0;
        tick();
        check("rst_reqready", int'(ReqReady), 1);

        // Basic burst: addr 2, count 3
        push(3, 2, 0);
        push(4, 3, 0);
        push(5, 4, 1);
        request(2, 3);
        check("basic_t1_busy", int'(Busy), 1);
        check("basic_t1_reqready", int'(ReqReady), 0);
        tick();
        tick();
        check("basic_t3_valid", int'(OutValid), 1);
        tick();
        check("basic_t4_reqready", int'(ReqReady), 1);
        check("basic_t4_busy", int'(Busy), 0);
        check("basic_sb_empty", sb.size(), 0);

        // Wrap plus backpressure on the second word
        push(7, 6, 0);
        push(8, 7, 0);
        push(1, 0, 0);
        push(2, 1, 1);
        request(6, 4);
        tick();
        OutReady = 1'b0;
        tick();
        check("bp_hold_addr", int'(OutAddr), 7);
        tick();
        OutReady = 1'b1;
        tick();
        tick();
        check("wrap_last_addr", int'(OutAddr), 1);
        check("wrap_last_flag", int'(OutLast), 1);
        wait_idle("wrap");
        check("wrap_sb_empty", sb.size(), 0);

        // Zero count is accepted and dropped
        request(3, 0);
        check("zero_outvalid", int'(OutValid), 0);
        check("zero_busy", int'(Busy), 0);
        check("zero_reqready", int'(ReqReady), 1);

        // ReqValid during SEND is ignored
        push(1, 0, 0);
        push(2, 1, 0);
        push(3, 2, 1);
        request(0, 3);
        ReqValid = 1'b1;
        ReqAddr  = 3'd5;
        ReqCount = 4'd2;
        tick();
        ReqValid = 1'b0;
        wait_idle("ignore");
        tick();
        check("ignore_outvalid", int'(OutValid), 0);
        check("ignore_sb_empty", sb.size(), 0);

        // Reset during the second of four words
        push(1, 0, 0);
        push(2, 1, 0);
        push(3, 2, 0);
        push(4, 3, 1);
        request(0, 4);
        tick();
        OutReady = 1'b0;
        Reset    = 1'b1;
        tick();
        Reset    = 1'b0;
        OutReady = 1'b1;
        sb.delete();
        check("midrst_outvalid", int'(OutValid), 0);
        check("midrst_busy", int'(Busy), 0);
        check("midrst_outdata", int'(OutData), 0);
        check("midrst_reqready", int'(ReqReady), 1);
        push(1, 0, 1);
        request(0, 1);
        tick();
        check("midrst_new_done", int'(ReqReady), 1);
        check("midrst_sb_empty", sb.size(), 0);

        // Bank change in cycle T+1 of a 2-word burst
        push(1, 0, 0);
`ifdef REG_READER_SNAPSHOT_EN
        push(2, 1, 1);
`else
        push(15, 1, 1);
`endif
        request(0, 2);
        BankData[4 +: 4] = 4'hF;
        wait_idle("bankchg");
        BankData = default_bank();
        check("bankchg_sb_empty", sb.size(), 0);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
